// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit slice: the serialiser state
// encoding, the data width and the default bit period.
//
// Contents:
//   DATA_W            width of one serial character (8 bits)
//   BAUD_DIV_DEFAULT  CLK_SYS cycles per serial bit (50 MHz / 115200)
//   tx_state_t        serialiser FSM states (PARITY is only reachable when
//                     the design is built with UART_PARITY_EN defined)
//   even_parity()     even-parity bit of one character
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_W           = 8;
  localparam int BAUD_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity: the extra bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Small synchronous first-in first-out byte buffer sitting between the
// producer write strobe and the serialiser.
//
// Parameters:
//   FIFO_AW   address width; depth is 2**FIFO_AW entries
//
// Ports:
//   CLK_SYS   in   system clock, rising edge
//   CLK_RST   in   synchronous active-high reset (empties the buffer)
//   wr_en     in   write request
//   wr_data   in   byte to store
//   rd_en     in   pop request; ignored while empty
//   rd_data   out  oldest stored byte, valid whenever empty is low
//   empty     out  no bytes stored
//   full      out  registered flag, high when count equals the depth
// ----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 2
) (
  input  logic              CLK_SYS,
  input  logic              CLK_RST,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full
);

  localparam int             DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic               full_q;
  logic               do_rd;
  logic               do_wr;

  // A pop frees a slot in the same cycle, so a write that coincides with a
  // pop on a full buffer is still accepted.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && (!full_q || do_rd);

  // Occupancy after this cycle's write and pop.
  always_comb begin
    count_nxt = count;
    case ({do_wr, do_rd})
      2'b10:   count_nxt = count + (FIFO_AW+1)'(1);
      2'b01:   count_nxt = count - (FIFO_AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because they are exactly FIFO_AW bits wide; the
  // full flag is registered from the same next-count as the counter.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + FIFO_AW'(1);
      count  <= count_nxt;
      full_q <= (count_nxt == DEPTH_CNT);
    end
  end

  // Storage array needs no reset: entries are only read after being written.
  always_ff @(posedge CLK_SYS) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = full_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_ctrl
// Serial transmit stage behind the phase-detector/PWM block. Rising edges of
// Uart_En write Uart_Data into a small FIFO; a serialiser drains the FIFO as
// 8N1 asynchronous frames (8E1 when UART_PARITY_EN is defined), running
// frames back to back while bytes are waiting.
//
// Build option:
//   UART_PARITY_EN   when defined, an even-parity bit follows the 8 data bits
//
// Parameters:
//   BAUD_DIV   CLK_SYS cycles per serial bit, 2..65535
//   FIFO_AW    FIFO address width, depth 2**FIFO_AW
//
// Ports:
//   CLK_SYS    in   system clock, rising edge
//   CLK_RST    in   synchronous active-high reset; aborts any frame
//   Uart_En    in   byte-valid level; only its rising edge writes
//   Uart_Data  in   byte sampled on the write cycle
//   Uart_Busy  out  FIFO full
//   Uart_Tx    out  serial line, idle high
//   Tx_Active  out  high from start bit through stop bit
//   Uart_Ovf   out  sticky flag: a write was dropped on a full FIFO
// ----------------------------------------------------------------------------
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
  parameter int FIFO_AW  = 2
) (
  input  logic              CLK_SYS,
  input  logic              CLK_RST,
  input  logic              Uart_En,
  input  logic [DATA_W-1:0] Uart_Data,
  output logic              Uart_Busy,
  output logic              Uart_Tx,
  output logic              Tx_Active,
  output logic              Uart_Ovf
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [15:0]       baud_cnt;
  logic [15:0]       baud_nxt;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_nxt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_nxt;
  logic              tx_nxt;
  logic              active_nxt;
  logic              en_prev;
  logic              wr_stb;
  logic              pop;
  logic              bit_end;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_full;
`ifdef UART_PARITY_EN
  logic              parity_q;
  logic              parity_nxt;
`endif

  // The producer holds Uart_En as a level, so only its rising edge is a
  // write. en_prev clears on reset, which makes a level already high on the
  // first cycle afterwards count as an edge.
  assign wr_stb = Uart_En && !en_prev;

  uart_sync_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .CLK_SYS (CLK_SYS),
    .CLK_RST (CLK_RST),
    .wr_en   (wr_stb),
    .wr_data (Uart_Data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign Uart_Busy = fifo_full;
  assign bit_end   = (baud_cnt == BAUD_LAST);

  // Next-state logic. A pop happens either from IDLE or at the last cycle of
  // a stop bit, so consecutive frames run with no idle gap. The line value
  // and Tx_Active are derived from the next state and registered, which puts
  // the start bit on the line the cycle after the pop.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift_reg;
    pop       = 1'b0;
`ifdef UART_PARITY_EN
    parity_nxt = parity_q;
`endif

    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) pop = 1'b1;
      end

      START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = shift_reg >> 1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end

`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = STOP;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = IDLE;
        end else begin
          baud_nxt = baud_cnt + 16'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
      end
    endcase

    // Loading a byte always starts a fresh frame with a cleared bit timer.
    if (pop) begin
      shift_nxt = fifo_rd_data;
      baud_nxt  = '0;
      state_nxt = START;
`ifdef UART_PARITY_EN
      parity_nxt = even_parity(fifo_rd_data);
`endif
    end

    tx_nxt = 1'b1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_nxt = parity_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase

    active_nxt = (state_nxt != IDLE);
  end

  // State and output registers; reset drops the line high immediately.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      Uart_Tx   <= 1'b1;
      Tx_Active <= 1'b0;
      en_prev   <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_idx   <= bit_nxt;
      shift_reg <= shift_nxt;
      Uart_Tx   <= tx_nxt;
      Tx_Active <= active_nxt;
      en_prev   <= Uart_En;
`ifdef UART_PARITY_EN
      parity_q  <= parity_nxt;
`endif
    end
  end

  // Overflow only when the write truly finds no room; a same-cycle pop
  // makes room and the FIFO accepts the byte.
  always_ff @(posedge CLK_SYS) begin
    if (CLK_RST) begin
      Uart_Ovf <= 1'b0;
    end else if (wr_stb && fifo_full && !pop) begin
      Uart_Ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_ctrl
// Bench for uart_tx_fifo_ctrl with BAUD_DIV=4, FIFO_AW=2. Bytes expected on
// the line are queued when written; a line monitor decodes each frame,
// pops the queue and compares every cycle of the frame.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo_ctrl;

  localparam int BAUD    = 4;
  localparam int FIFO_AW = 2;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * BAUD;

  logic       CLK_SYS = 1'b0;
  logic       CLK_RST;
  logic       Uart_En;
  logic [7:0] Uart_Data;
  logic       Uart_Busy;
  logic       Uart_Tx;
  logic       Tx_Active;
  logic       Uart_Ovf;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  int         frames_seen = 0;
  int         cyc = 0;
  int         rst_edges = 0;
  logic       mon_busy = 1'b0;

  uart_tx_fifo_ctrl #(
    .BAUD_DIV (BAUD),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .CLK_SYS   (CLK_SYS),
    .CLK_RST   (CLK_RST),
    .Uart_En   (Uart_En),
    .Uart_Data (Uart_Data),
    .Uart_Busy (Uart_Busy),
    .Uart_Tx   (Uart_Tx),
    .Tx_Active (Tx_Active),
    .Uart_Ovf  (Uart_Ovf)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  // Cycle stamp and count of reset edges, used by the monitor to drop a
  // frame that reset cut short.
  always @(posedge CLK_SYS) begin
    cyc <= cyc + 1;
    if (CLK_RST) rst_edges <= rst_edges + 1;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decodes one frame starting at the current negedge (start bit already seen).
  task automatic decode_frame();
    logic [7:0]            exp_byte;
    logic [FRAME_BITS-1:0] bits;
    int                    rst_mark;
    bit                    have_exp;
    bit                    bad;
    bit                    aborted;
    int                    bad_at;
    logic                  bad_tx;
    logic                  bad_exp;
    logic                  bad_act;
    mon_busy = 1'b1;
    rst_mark = rst_edges;
    frame_starts.push_back(cyc);
    have_exp = (exp_q.size() != 0);
    checks++;
    if (!have_exp) begin
      errors++;
      $display("[TB] FAIL unexpected_frame: frame started at cycle %0d, required none (queue empty)", cyc);
      exp_byte = '0;
    end else begin
      exp_byte = exp_q.pop_front();
    end
    bits = '0;
    bits[8:1] = exp_byte;
`ifdef UART_PARITY_EN
    bits[9] = ^exp_byte;
`endif
    bits[FRAME_BITS-1] = 1'b1;
    bad = 0; aborted = 0; bad_at = 0; bad_tx = 1'b0; bad_exp = 1'b0; bad_act = 1'b0;
    for (int j = 0; j < FRAME_CYC; j++) begin
      if (j > 0) @(negedge CLK_SYS);
      if (rst_edges != rst_mark) begin
        aborted = 1;
        break;
      end
      if (!bad && (Uart_Tx !== bits[j / BAUD] || Tx_Active !== 1'b1)) begin
        bad = 1; bad_at = j; bad_tx = Uart_Tx; bad_exp = bits[j / BAUD]; bad_act = Tx_Active;
      end
    end
    if (!aborted) begin
      frames_seen++;
      if (have_exp) begin
        checks++;
        if (bad) begin
          errors++;
          $display("[TB] FAIL frame_%02h: cycle %0d of frame got Uart_Tx=%b Tx_Active=%b, required Uart_Tx=%b Tx_Active=1",
                   exp_byte, bad_at, bad_tx, bad_act, bad_exp);
        end
      end
    end
    mon_busy = 1'b0;
  endtask

  initial begin : line_monitor
    forever begin
      @(negedge CLK_SYS);
      if (CLK_RST === 1'b0 && Uart_Tx === 1'b0) decode_frame();
    end
  end

  // One-cycle pulse on Uart_En starting at the current negedge.
  task automatic write_byte(input logic [7:0] d, input bit accept);
    Uart_Data = d;
    Uart_En   = 1'b1;
    if (accept) exp_q.push_back(d);
    @(negedge CLK_SYS);
    Uart_En = 1'b0;
    @(negedge CLK_SYS);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && Tx_Active === 1'b0) && n < 3000) begin
      @(negedge CLK_SYS);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("[TB] FAIL drain_%s: %0d bytes still pending after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    CLK_RST   = 1'b1;
    Uart_En   = 1'b0;
    Uart_Data = 8'h00;
    repeat (3) @(negedge CLK_SYS);
    checks++; if (Uart_Tx !== 1'b1)   begin errors++; $display("[TB] FAIL reset_tx: got %b, required 1", Uart_Tx); end
    checks++; if (Tx_Active !== 1'b0) begin errors++; $display("[TB] FAIL reset_active: got %b, required 0", Tx_Active); end
    checks++; if (Uart_Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", Uart_Busy); end
    checks++; if (Uart_Ovf !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ovf: got %b, required 0", Uart_Ovf); end
    CLK_RST = 1'b0;
    repeat (2) @(negedge CLK_SYS);
  endtask

  task automatic test_single();
    int n_act;
    Uart_Data = 8'hA5;
    Uart_En   = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge CLK_SYS);
    Uart_En = 1'b0;
    checks++;
    if (Uart_Tx !== 1'b1) begin errors++; $display("[TB] FAIL latency_early: Uart_Tx got %b one cycle after write, required 1", Uart_Tx); end
    @(negedge CLK_SYS);
    checks++;
    if (Uart_Tx !== 1'b0 || Tx_Active !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency_start: Uart_Tx=%b Tx_Active=%b two cycles after write, required 0 and 1", Uart_Tx, Tx_Active);
    end
    n_act = 0;
    while (Tx_Active === 1'b1 && n_act < 1000) begin
      n_act++;
      @(negedge CLK_SYS);
    end
    checks++;
    if (n_act != FRAME_CYC) begin errors++; $display("[TB] FAIL active_len: got %0d cycles, required %0d", n_act, FRAME_CYC); end
    checks++;
    if (Uart_Tx !== 1'b1) begin errors++; $display("[TB] FAIL idle_line: got %b after frame, required 1", Uart_Tx); end
    wait_drain("single");
  endtask

  task automatic test_hold();
    int f0;
    f0 = frames_seen;
    Uart_Data = 8'h3C;
    Uart_En   = 1'b1;
    exp_q.push_back(8'h3C);
    repeat (100) @(negedge CLK_SYS);
    Uart_En = 1'b0;
    repeat (FRAME_CYC + 10) @(negedge CLK_SYS);
    wait_drain("hold");
    checks++;
    if (frames_seen - f0 != 1) begin errors++; $display("[TB] FAIL hold_frames: got %0d frames, required 1", frames_seen - f0); end
  endtask

  task automatic test_six_writes();
    frame_starts.delete();
    for (int i = 1; i <= 6; i++) begin
      write_byte(8'(i), i <= 5);
      if (i == 4) begin
        checks++;
        if (Uart_Busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_4: got %b, required 0", Uart_Busy); end
      end
      if (i == 5) begin
        checks++;
        if (Uart_Busy !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_5: got %b, required 1", Uart_Busy); end
        checks++;
        if (Uart_Ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_after_5: got %b, required 0", Uart_Ovf); end
      end
    end
    checks++;
    if (Uart_Ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_after_6: got %b, required 1", Uart_Ovf); end
    wait_drain("six");
    checks++;
    if (frame_starts.size() != 5) begin
      errors++;
      $display("[TB] FAIL six_frames: got %0d frames, required 5", frame_starts.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        checks++;
        if (frame_starts[k] - frame_starts[k-1] != FRAME_CYC) begin
          errors++;
          $display("[TB] FAIL gap_%0d: start spacing %0d cycles, required %0d", k, frame_starts[k] - frame_starts[k-1], FRAME_CYC);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    checks++;
    if (Uart_Ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b, required 1", Uart_Ovf); end
    write_byte(8'h55, 1);      // returns on frame cycle 0
    write_byte(8'h66, 1);
    write_byte(8'h77, 1);      // now frame cycle 4
    repeat (13) @(negedge CLK_SYS);   // cycle 17: data bit 3
    CLK_RST = 1'b1;
    @(negedge CLK_SYS);
    CLK_RST = 1'b0;
    exp_q.delete();
    checks++; if (Uart_Tx !== 1'b1)   begin errors++; $display("[TB] FAIL abort_tx: got %b, required 1", Uart_Tx); end
    checks++; if (Tx_Active !== 1'b0) begin errors++; $display("[TB] FAIL abort_active: got %b, required 0", Tx_Active); end
    checks++; if (Uart_Busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, required 0", Uart_Busy); end
    checks++; if (Uart_Ovf !== 1'b0)  begin errors++; $display("[TB] FAIL abort_ovf: got %b, required 0", Uart_Ovf); end
    f0 = frames_seen;
    repeat (200) @(negedge CLK_SYS);
    checks++;
    if (frames_seen != f0 || Uart_Tx !== 1'b1 || Tx_Active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL quiet_after_reset: frames=%0d Uart_Tx=%b Tx_Active=%b, required 0 frames, 1, 0",
               frames_seen - f0, Uart_Tx, Tx_Active);
    end
  endtask

  // FIFO is full while the serialiser pops at the end of the first stop bit;
  // a write on that very cycle lands. Six bytes are accepted in total.
  task automatic test_full_pop();
    int f0;
    f0 = frames_seen;
    write_byte(8'h11, 1);      // frame cycle 0
    checks++;
    if (Uart_Tx !== 1'b0) begin errors++; $display("[TB] FAIL fp_start: got %b, required 0", Uart_Tx); end
    for (int i = 0; i < 4; i++) write_byte(8'(8'h12 + i), 1);   // frame cycle 8
    checks++;
    if (Uart_Busy !== 1'b1) begin errors++; $display("[TB] FAIL fp_full: got %b, required 1", Uart_Busy); end
    repeat (FRAME_CYC - 1 - 8) @(negedge CLK_SYS);   // last cycle of stop bit
    Uart_Data = 8'h16;
    Uart_En   = 1'b1;
    exp_q.push_back(8'h16);
    @(negedge CLK_SYS);
    Uart_En = 1'b0;
    checks++;
    if (Uart_Ovf !== 1'b0) begin errors++; $display("[TB] FAIL fp_ovf: got %b, required 0", Uart_Ovf); end
    checks++;
    if (Uart_Busy !== 1'b1) begin errors++; $display("[TB] FAIL fp_busy: got %b, required 1", Uart_Busy); end
    wait_drain("full_pop");
    checks++;
    if (frames_seen - f0 != 6) begin errors++; $display("[TB] FAIL fp_frames: got %0d frames, required 6", frames_seen - f0); end
    checks++;
    if (Uart_Ovf !== 1'b0) begin errors++; $display("[TB] FAIL fp_ovf_end: got %b, required 0", Uart_Ovf); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    write_byte(8'h07, 1);
    repeat (37) @(negedge CLK_SYS);
    checks++;
    if (Uart_Tx !== 1'b1) begin errors++; $display("[TB] FAIL parity_07: got %b, required 1", Uart_Tx); end
    wait_drain("par07");
    write_byte(8'h03, 1);
    repeat (37) @(negedge CLK_SYS);
    checks++;
    if (Uart_Tx !== 1'b0) begin errors++; $display("[TB] FAIL parity_03: got %b, required 0", Uart_Tx); end
    wait_drain("par03");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_six_writes();
    test_reset_mid_frame();
    test_full_pop();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
